synchronous_multichannel_fifo_controller: RTL
=============================================

Name: synchronous_multichannel_fifo_controller

Overview:
- Single-clock controller for CHANNELS independent FIFO queues sharing one external memory of CHANNELS*DEPTH entries.
- Channel c owns the address region [c*DEPTH, c*DEPTH+DEPTH-1].
- Provides per-channel level, status flags, programmable thresholds and flush, plus write-miss and read-error flags.
- Sits in front of a simple dual-port RAM. It is the multichannel, single-clock successor of the advanced FIFO controllers and supports any DEPTH ≥ 2 (power of two not required).

Parameters:
- WIDTH, 8, data width.
- DEPTH, 5, entries per channel, ≥ 2, any value.
- CHANNELS, 4, number of queues, ≥ 2.
- DEPTH_LOG2, CLOG2(DEPTH), pointer width.
- CHANNEL_LOG2, CLOG2(CHANNELS), channel-select width.
- ADDRESS_WIDTH, CLOG2(CHANNELS*DEPTH), memory address width.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  CHANNELS  per-channel flush request.
- write_enable  in  1  write request.
- write_channel  in  CHANNEL_LOG2  target queue of the write.
- write_data  in  WIDTH  data to write.
- read_enable  in  1  read request.
- read_channel  in  CHANNEL_LOG2  source queue of the read.
- read_data  out  WIDTH  head of read_channel (combinational from memory).
- empty  out  CHANNELS  per-channel empty.
- almost_empty  out  CHANNELS  level==1.
- almost_full  out  CHANNELS  level==DEPTH-1.
- full  out  CHANNELS  level==DEPTH.
- level  out  CHANNELS*(DEPTH_LOG2+1)  packed per-channel level; channel c at [c*(DEPTH_LOG2+1) +: DEPTH_LOG2+1].
- lower_threshold_level  in  DEPTH_LOG2+1  common lower threshold.
- lower_threshold_status  out  CHANNELS  level ≤ lower_threshold_level.
- upper_threshold_level  in  DEPTH_LOG2+1  common upper threshold.
- upper_threshold_status  out  CHANNELS  level ≥ upper_threshold_level.
- write_miss  out  1  registered; write was rejected last cycle.
- read_error  out  1  registered; read was rejected last cycle.
- memory_write_enable  out  1  RAM write strobe.
- memory_write_address  out  ADDRESS_WIDTH  RAM write address.
- memory_write_data  out  WIDTH  RAM write data.
- memory_read_enable  out  1  tied 1.
- memory_read_address  out  ADDRESS_WIDTH  RAM read address.
- memory_read_data  in  WIDTH  RAM read data, combinational.

Behaviour:
- State per channel: write pointer, read pointer (0..DEPTH-1, wrap DEPTH-1→0), level counter (0..DEPTH).
- Reset (synchronous, active-high):
  - All pointers and levels 0.
  - write_miss=0, read_error=0.
  - empty=all-ones, full=0, almost flags=0.
- Acceptance rules:
  - do_write = write_enable && !full[write_channel] && !flush[write_channel].
  - do_read = read_enable && !empty[read_channel] && !flush[read_channel].
  - Flags are evaluated on registered state; there is no same-cycle bypass.
  - A write to a full channel is rejected even if the same channel is read that cycle.
  - A read of an empty channel is rejected even if the same channel is written that cycle.
- Level update:
  - do_write and do_read on the same channel: level unchanged, both pointers advance.
  - Different channels: each channel updates independently.
- Flush:
  - Next cycle: level=0 and read pointer := write pointer for that channel.
  - Flush overrides any write or read on that channel.
  - Other channels are unaffected.
  - A flush request is never a miss or error.
- Addresses:
  - memory_write_address = write_channel*DEPTH + write pointer of that channel.
  - memory_read_address = read_channel*DEPTH + read pointer of that channel.
  - Implement with a constant multiply or shift-add; no divider.
- read_data = memory_read_data, with zero-cycle latency relative to read_channel.
- Out-of-range channel (≥ CHANNELS):
  - Write is treated as full and raises write_miss.
  - Read is treated as empty and raises read_error.
  - No state change.
- write_miss: set for 1 cycle after write_enable && !do_write && !flush[write_channel].
- read_error: set for 1 cycle after read_enable && !do_read && !flush[read_channel].
- Flags and threshold statuses are combinational from the level registers. Latency from accepted write to level/flag update is 1 cycle.

Decomposition:
- Package synchronous_multichannel_fifo_pkg:
  - CLOG2-derived widths.
  - Function channel_base(c) = c*DEPTH.
- Sub-module fifo_channel_state, instantiated CHANNELS times, one per channel. It holds the pointers, the level counter, flush handling and flag generation, with inputs write_strobe, read_strobe and flush.
- The top level does channel decode, the address mux and the miss/error registers.

Test Plan (CHANNELS=4, DEPTH=5, WIDTH=8):
- Reset, then write 0x11,0x22 to channel 2 → level[2]=2, read of channel 2 returns 0x11 then 0x22, empty[2]=1 afterwards; other channels level 0.
- Write 5 entries to channel 1, then a 6th → full[1]=1, almost_full[1]=1 after 4th entry, write_miss=1 for one cycle, memory_write_enable=0 on 6th; write addresses 5..9.
- Wrap: channel 3, 12 writes interleaved with reads → addresses cycle 15..19 within region only, data order preserved, never touches 0..14.
- Simultaneous write and read on channel 0 at level 3 → level stays 3; at level 5 (full), read accepted, write rejected with write_miss=1, level becomes 4.
- flush[1] with level[1]=4 and a concurrent write to channel 1 → next cycle level[1]=0, empty[1]=1, write_miss=0, channel 2 contents intact.
- Read from empty channel 0 and from write_channel=… read_channel=3 with level 0 → read_error=1 one cycle; lower_threshold_level=1, upper_threshold_level=4 → statuses track level[c] ≤ 1 and ≥ 4 exactly.

Source files
------------

// File: rtl/synchronous_multichannel_fifo_pkg.sv
// Shared types and helpers for the multichannel FIFO controller.
// Every channel owns a fixed, contiguous slice of one shared RAM.
package synchronous_multichannel_fifo_pkg;

  // Per-channel status, all decoded from the level register.
  typedef struct packed {
    logic empty;
    logic almost_empty;
    logic almost_full;
    logic full;
    logic lower_status;
    logic upper_status;
  } chan_flags_t;

  // The number of bits needed to hold values 0..n-1. It is never less than 1.
  function automatic int index_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // The first RAM address of channel c. Both arguments are elaboration-time
  // constants or a small channel index, so this maps to a constant multiply.
  function automatic int channel_base(input int c, input int depth);
    return c * depth;
  endfunction

endpackage

// File: rtl/synchronous_multichannel_fifo_controller_channel.sv
// Per-channel queue state: the write and read pointers, the level, the flush
// and the status flags. The strobes arrive already qualified by the top level.
module fifo_channel_state
  import synchronous_multichannel_fifo_pkg::*;
#(
  parameter int DEPTH = 5,
  parameter int PTR_W = 3,
  parameter int LVL_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             write_strobe,
  input  logic             read_strobe,
  input  logic             flush,
  input  logic [LVL_W-1:0] lower_threshold_level,
  input  logic [LVL_W-1:0] upper_threshold_level,
  output logic [PTR_W-1:0] write_pointer,
  output logic [PTR_W-1:0] read_pointer,
  output logic [LVL_W-1:0] level,
  output chan_flags_t      flags
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  // DEPTH does not have to be a power of two, so the wrap is explicit.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      // Drop everything in the queue. The write pointer stays where it is.
      level_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (write_strobe) wr_ptr_d = next_ptr(wr_ptr_q);
      if (read_strobe)  rd_ptr_d = next_ptr(rd_ptr_q);
      if (write_strobe && !read_strobe)      level_d = level_q + 1'b1;
      else if (read_strobe && !write_strobe) level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign write_pointer      = wr_ptr_q;
  assign read_pointer       = rd_ptr_q;
  assign level              = level_q;
  assign flags.empty        = (level_q == '0);
  assign flags.almost_empty = (level_q == LVL_W'(1));
  assign flags.almost_full  = (level_q == LVL_W'(DEPTH-1));
  assign flags.full         = (level_q == LVL_W'(DEPTH));
  assign flags.lower_status = (level_q <= lower_threshold_level);
  assign flags.upper_status = (level_q >= upper_threshold_level);

endmodule

// File: rtl/synchronous_multichannel_fifo_controller.sv
// Single-clock controller for CHANNELS FIFO queues that share one dual-port RAM.
// It does the channel decode, the RAM address muxing and the miss/error flags.
module synchronous_multichannel_fifo_controller
  import synchronous_multichannel_fifo_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 5,
  parameter int CHANNELS      = 4,
  parameter int DEPTH_LOG2    = index_width(DEPTH),
  parameter int CHANNEL_LOG2  = index_width(CHANNELS),
  parameter int ADDRESS_WIDTH = index_width(CHANNELS*DEPTH)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [CHANNELS-1:0]                  flush,
  input  logic                                 write_enable,
  input  logic [CHANNEL_LOG2-1:0]              write_channel,
  input  logic [WIDTH-1:0]                     write_data,
  input  logic                                 read_enable,
  input  logic [CHANNEL_LOG2-1:0]              read_channel,
  output logic [WIDTH-1:0]                     read_data,
  output logic [CHANNELS-1:0]                  empty,
  output logic [CHANNELS-1:0]                  almost_empty,
  output logic [CHANNELS-1:0]                  almost_full,
  output logic [CHANNELS-1:0]                  full,
  output logic [CHANNELS*(DEPTH_LOG2+1)-1:0]   level,
  input  logic [DEPTH_LOG2:0]                  lower_threshold_level,
  output logic [CHANNELS-1:0]                  lower_threshold_status,
  input  logic [DEPTH_LOG2:0]                  upper_threshold_level,
  output logic [CHANNELS-1:0]                  upper_threshold_status,
  output logic                                 write_miss,
  output logic                                 read_error,
  output logic                                 memory_write_enable,
  output logic [ADDRESS_WIDTH-1:0]             memory_write_address,
  output logic [WIDTH-1:0]                     memory_write_data,
  output logic                                 memory_read_enable,
  output logic [ADDRESS_WIDTH-1:0]             memory_read_address,
  input  logic [WIDTH-1:0]                     memory_read_data
);

  localparam int LVL_W = DEPTH_LOG2 + 1;

  logic [CHANNELS-1:0]   wr_strobe, rd_strobe;
  logic [DEPTH_LOG2-1:0] wr_ptr [CHANNELS];
  logic [DEPTH_LOG2-1:0] rd_ptr [CHANNELS];
  logic [LVL_W-1:0]      lvl    [CHANNELS];
  chan_flags_t           flg    [CHANNELS];

  logic                  wr_sel_full, wr_sel_flush, rd_sel_empty, rd_sel_flush;
  logic [DEPTH_LOG2-1:0] wr_sel_ptr, rd_sel_ptr;
  logic                  do_write, do_read;
  logic                  write_miss_q, write_miss_d, read_error_q, read_error_d;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    fifo_channel_state #(.DEPTH(DEPTH), .PTR_W(DEPTH_LOG2), .LVL_W(LVL_W)) u_state (
      .clock                 (clock),
      .reset                 (reset),
      .write_strobe          (wr_strobe[g]),
      .read_strobe           (rd_strobe[g]),
      .flush                 (flush[g]),
      .lower_threshold_level (lower_threshold_level),
      .upper_threshold_level (upper_threshold_level),
      .write_pointer         (wr_ptr[g]),
      .read_pointer          (rd_ptr[g]),
      .level                 (lvl[g]),
      .flags                 (flg[g])
    );
    assign empty[g]                  = flg[g].empty;
    assign almost_empty[g]           = flg[g].almost_empty;
    assign almost_full[g]            = flg[g].almost_full;
    assign full[g]                   = flg[g].full;
    assign lower_threshold_status[g] = flg[g].lower_status;
    assign upper_threshold_status[g] = flg[g].upper_status;
    assign level[g*LVL_W +: LVL_W]   = lvl[g];
  end

  // If a channel index does not match any channel, the write side treats it
  // as full and the read side treats it as empty. Such a request is rejected
  // and it is never taken as a flush.
  always_comb begin
    wr_sel_full  = 1'b1;
    wr_sel_flush = 1'b0;
    wr_sel_ptr   = '0;
    rd_sel_empty = 1'b1;
    rd_sel_flush = 1'b0;
    rd_sel_ptr   = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (int'(write_channel) == c) begin
        wr_sel_full  = full[c];
        wr_sel_flush = flush[c];
        wr_sel_ptr   = wr_ptr[c];
      end
      if (int'(read_channel) == c) begin
        rd_sel_empty = empty[c];
        rd_sel_flush = flush[c];
        rd_sel_ptr   = rd_ptr[c];
      end
    end
    do_write     = write_enable && !wr_sel_full && !wr_sel_flush;
    do_read      = read_enable && !rd_sel_empty && !rd_sel_flush;
    write_miss_d = write_enable && !do_write && !wr_sel_flush;
    read_error_d = read_enable && !do_read && !rd_sel_flush;
    for (int c = 0; c < CHANNELS; c++) begin
      wr_strobe[c] = do_write && (int'(write_channel) == c);
      rd_strobe[c] = do_read && (int'(read_channel) == c);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      write_miss_q <= 1'b0;
      read_error_q <= 1'b0;
    end else begin
      write_miss_q <= write_miss_d;
      read_error_q <= read_error_d;
    end
  end

  assign write_miss           = write_miss_q;
  assign read_error           = read_error_q;
  assign memory_write_enable  = do_write;
  assign memory_write_data    = write_data;
  assign memory_write_address = ADDRESS_WIDTH'(channel_base(int'(write_channel), DEPTH))
                              + ADDRESS_WIDTH'(wr_sel_ptr);
  assign memory_read_enable   = 1'b1;
  assign memory_read_address  = ADDRESS_WIDTH'(channel_base(int'(read_channel), DEPTH))
                              + ADDRESS_WIDTH'(rd_sel_ptr);
  assign read_data            = memory_read_data;

endmodule
